// File: rtl/decoder_pkg.sv
// Shared widths and types for the LED-array column-select decoder.
// Holds the default index/output widths and the matching packed types.
package decoder_pkg;

    localparam int unsigned DEC_IN_W  = 3;
    localparam int unsigned DEC_OUT_W = 8;

    typedef logic [DEC_IN_W-1:0]  dec_idx_t;
    typedef logic [DEC_OUT_W-1:0] dec_sel_t;

endpackage

// File: rtl/decoder_scan_counter.sv
// Internal column scan counter: prescaler, scan index and frame pulse.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   advance      count enable (ena & scan_en from the top)
//   scan_idx     current column index, wraps max->0
//   frame_start  one-cycle registered pulse when scan_idx wraps to 0
module decoder_scan_counter
    import decoder_pkg::*;
#(
    parameter int unsigned IN_W     = DEC_IN_W,
    parameter int          SCAN_DIV = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            advance,
    output logic [IN_W-1:0] scan_idx,
    output logic            frame_start
);

    localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);

    logic [PRE_W-1:0] pre;
    logic             pre_wrap_c;
    logic             idx_wrap_c;

    // A scan step happens on the prescaler's last count; the frame wraps on the last column.
    assign pre_wrap_c = advance && (pre == PRE_MAX);
    assign idx_wrap_c = pre_wrap_c && (scan_idx == '1);

    // Counters hold (not clear) whenever advance is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre         <= '0;
            scan_idx    <= '0;
            frame_start <= 1'b0;
        end else begin
            if (advance) begin
                pre <= pre_wrap_c ? '0 : pre + PRE_W'(1);
            end
            if (pre_wrap_c) begin
                scan_idx <= scan_idx + IN_W'(1);
            end
            frame_start <= idx_wrap_c;
        end
    end

endmodule

// File: rtl/decoder_3to8.sv
// One-hot column-select decoder for the 8x8 LED array driver.
// Selects either the external index x or the internal scan counter and
// decodes it into a one-hot column select, combinationally (y) and
// registered (y_q).
// Build option: define DECODER_ACTIVE_LOW_EN for one-cold y/y_q
// (idle value all ones, y_q resets to all ones).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   ena          global enable; low forces all selects inactive
//   x            external index; top bit flags out-of-range
//   scan_en      1 = index from scan counter, 0 = from x
//   y            combinational decode of the selected index
//   y_q          y registered on rising clk
//   scan_idx     current scan counter value
//   frame_start  one-cycle pulse when the scan counter wraps to 0
module decoder_3to8
    import decoder_pkg::*;
#(
    parameter int unsigned IN_W     = DEC_IN_W,
    parameter int          SCAN_DIV = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [IN_W:0]        x,
    input  logic                 scan_en,
    output logic [(2**IN_W)-1:0] y,
    output logic [(2**IN_W)-1:0] y_q,
    output logic [IN_W-1:0]      scan_idx,
    output logic                 frame_start
);

    localparam int unsigned OUT_W = 2 ** IN_W;

`ifdef DECODER_ACTIVE_LOW_EN
    localparam logic [OUT_W-1:0] Y_RST = '1;
`else
    localparam logic [OUT_W-1:0] Y_RST = '0;
`endif

    if (SCAN_DIV < 1) begin : g_bad_scan_div
        $error("decoder_3to8: SCAN_DIV must be >= 1");
    end

    logic [IN_W:0]      sel_c;
    logic [OUT_W-1:0]   hot_c;

    decoder_scan_counter #(
        .IN_W     (IN_W),
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk         (clk),
        .rst_n       (rst_n),
        .advance     (ena & scan_en),
        .scan_idx    (scan_idx),
        .frame_start (frame_start)
    );

    // Index source mux and one-hot decode; the top index bit means out of range.
    always_comb begin
        sel_c = scan_en ? {1'b0, scan_idx} : x;
        hot_c = '0;
        if (ena && !sel_c[IN_W]) begin
            hot_c[sel_c[IN_W-1:0]] = 1'b1;
        end
    end

`ifdef DECODER_ACTIVE_LOW_EN
    assign y = ~hot_c;
`else
    assign y = hot_c;
`endif

    // Registered copy of the select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= Y_RST;
        end else begin
            y_q <= y;
        end
    end

endmodule

// File: tb/tb_decoder_3to8.sv
// Self-checking bench for decoder_3to8: directed phases plus random traffic,
// checked against a counting model for SCAN_DIV=1 and SCAN_DIV=3 instances.
module tb_decoder_3to8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [3:0] x;
    logic       scan_en;

    logic [7:0] y1, yq1, y3, yq3;
    logic [2:0] idx1, idx3;
    logic       fs1, fs3;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: number of advancing cycles since reset, plus registered expectations.
    int         n1, n3;
    logic [7:0] yq1_m, yq3_m;
    logic       fs1_m, fs3_m;

`ifdef DECODER_ACTIVE_LOW_EN
    localparam logic [7:0] YQ_RST = 8'hFF;
`else
    localparam logic [7:0] YQ_RST = 8'h00;
`endif

    always #5 clk = ~clk;

    decoder_3to8 dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .x(x), .scan_en(scan_en),
        .y(y1), .y_q(yq1), .scan_idx(idx1), .frame_start(fs1)
    );

    decoder_3to8 #(.SCAN_DIV(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .x(x), .scan_en(scan_en),
        .y(y3), .y_q(yq3), .scan_idx(idx3), .frame_start(fs3)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_y(input logic e, input logic se,
                                         input logic [3:0] xi, input int idx);
        int         s;
        logic [7:0] v;
        s = se ? idx : int'(xi);
        v = 8'h00;
        if (e && s < 8) v = 8'(1 << s);
`ifdef DECODER_ACTIVE_LOW_EN
        v = ~v;
`endif
        return v;
    endfunction

    task automatic model_reset();
        n1 = 0; n3 = 0;
        yq1_m = YQ_RST; yq3_m = YQ_RST;
        fs1_m = 1'b0; fs3_m = 1'b0;
    endtask

    // Check all outputs at the falling edge, then advance the model across the rising edge.
    task automatic do_cycle();
        @(negedge clk);
        check_eq("y_div1",   32'(y1),   32'(exp_y(ena, scan_en, x, n1 % 8)));
        check_eq("y_div3",   32'(y3),   32'(exp_y(ena, scan_en, x, (n3 / 3) % 8)));
        check_eq("yq_div1",  32'(yq1),  32'(yq1_m));
        check_eq("yq_div3",  32'(yq3),  32'(yq3_m));
        check_eq("idx_div1", 32'(idx1), 32'(n1 % 8));
        check_eq("idx_div3", 32'(idx3), 32'((n3 / 3) % 8));
        check_eq("fs_div1",  32'(fs1),  32'(fs1_m));
        check_eq("fs_div3",  32'(fs3),  32'(fs3_m));
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            yq1_m = exp_y(ena, scan_en, x, n1 % 8);
            yq3_m = exp_y(ena, scan_en, x, (n3 / 3) % 8);
            if (ena && scan_en) begin
                n1++; n3++;
                fs1_m = (n1 % 8) == 0;
                fs3_m = (n3 % 24) == 0;
            end else begin
                fs1_m = 1'b0;
                fs3_m = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        // Reset with an active index applied.
        rst_n = 1'b0; ena = 1'b1; x = 4'd3; scan_en = 1'b0;
        model_reset();
        do_cycle();
        do_cycle();
        rst_n = 1'b1;

        // Exhaustive in-range direct decode.
        for (int i = 0; i < 8; i++) begin
            x = 4'(i);
            do_cycle();
        end

        // Guards: disabled, then out-of-range indices.
        ena = 1'b0; x = 4'd5;
        do_cycle();
        ena = 1'b1;
        for (int i = 8; i < 16; i++) begin
            x = 4'(i);
            do_cycle();
        end

        // Free-running scan through one wrap.
        x = 4'd0; scan_en = 1'b1;
        for (int i = 0; i < 10; i++) do_cycle();

        // Hold: disabled for 5 cycles, then resume.
        ena = 1'b0;
        for (int i = 0; i < 5; i++) do_cycle();
        ena = 1'b1;
        for (int i = 0; i < 30; i++) do_cycle();

        // Drive the fast scanner to column 5, then reset between edges.
        for (int i = 0; i < 16 && (n1 % 8) != 5; i++) do_cycle();
        check_eq("reach_idx5", 32'(idx1), 32'd5);
        rst_n = 1'b0;
        #2;
        check_eq("async_idx1", 32'(idx1), 32'd0);
        check_eq("async_idx3", 32'(idx3), 32'd0);
        check_eq("async_yq1",  32'(yq1),  32'(YQ_RST));
        check_eq("async_fs1",  32'(fs1),  32'd0);
        model_reset();
        do_cycle();
        rst_n = 1'b1;

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            ena     = ($urandom % 5) != 0;
            scan_en = ($urandom % 3) != 0;
            x       = 4'($urandom);
            do_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
